// File: rtl/ntt_intt_ip_pkg.sv
// Purpose: shared types and constants for the NTT/INTT IP and its host-side sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: operation codes, beat-counter width, sequencer state encoding, opcode check helper.
package ntt_intt_ip_pkg;

  // IP operation codes.
  localparam logic [5:0] OP_NULL = 6'h00;
  localparam logic [5:0] OP_NTT  = 6'h01;
  localparam logic [5:0] OP_INTT = 6'h02;

  // Width of the sequencer's load/store beat counter (indexes 0..255).
  localparam int SEQ_BEAT_W = 8;

  typedef enum logic [3:0] {
    SEQ_IDLE       = 4'd0,
    SEQ_LOAD_CMD   = 4'd1,
    SEQ_LOAD       = 4'd2,
    SEQ_START      = 4'd3,
    SEQ_COMP_WAIT  = 4'd4,
    SEQ_STORE_CMD  = 4'd5,
    SEQ_STORE      = 4'd6,
    SEQ_STORE_WAIT = 4'd7,
    SEQ_DONE       = 4'd8,
    SEQ_ERR        = 4'd9
  } seq_state_t;

  // Only NTT and INTT launch a job; anything else is rejected.
  function automatic logic op_is_valid(input logic [5:0] op);
    return (op == OP_NTT) || (op == OP_INTT);
  endfunction

endpackage

// File: rtl/ntt_intt_ip_seq_wdog.sv
// Purpose: clearable cycle counter with a terminal flag, used as the sequencer watchdog.
// Latency: expired_o is high in the LIMIT-th enabled cycle after a clear (cnt == LIMIT-1).
// Backpressure: none; counter holds at the terminal value once expired.
// Ports: clk_i/rst_ni (sync active-low), clr_i (zero the count), en_i (count this cycle),
//        expired_o (terminal count reached). Built only with NTT_INTT_SEQ_TIMEOUT_EN.
module ntt_intt_ip_seq_wdog #(
  parameter int LIMIT = 2048
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int CW = $clog2(LIMIT + 1);

  logic [CW-1:0] cnt_q;

  assign expired_o = (cnt_q == CW'(LIMIT - 1));

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (en_i && !expired_o) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/ntt_intt_ip_seq.sv
// Purpose: host-side job sequencer: load 256 coeffs, start, wait, store 256 results to the host.
// Latency: commands are decoded from state (0 cycles); result beats are registered (1 cycle).
// Backpressure: input stream via in_valid_i/in_ready_o; result stream has none (out_valid_o only).
// Ports: req_* job request handshake; in_* coefficient input stream; out_* result stream;
//        done_o/err_o job-end pulses; busy_o; ip_* command/data interface towards the IP.
// Config: define NTT_INTT_SEQ_TIMEOUT_EN to add a TIMEOUT_CYC watchdog on the IP wait states.
module ntt_intt_ip_seq
  import ntt_intt_ip_pkg::*;
#(
  parameter int N_COEFF     = 256,
  parameter int COEFF_W     = 12,
  parameter int TIMEOUT_CYC = 2048
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic [5:0]            req_op_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [COEFF_W-1:0]    in_data_i,
  output logic                  out_valid_o,
  output logic [COEFF_W-1:0]    out_data_o,
  output logic [SEQ_BEAT_W-1:0] out_idx_o,
  output logic                  done_o,
  output logic                  err_o,
  output logic                  busy_o,
  output logic                  ip_load_o,
  output logic                  ip_start_o,
  output logic                  ip_store_o,
  output logic                  ip_load_en_o,
  output logic [COEFF_W-1:0]    ip_wdata_o,
  output logic [5:0]            ip_operation_o,
  input  logic                  ip_rdata_valid_i,
  input  logic [COEFF_W-1:0]    ip_rdata_i,
  input  logic                  ip_intr_i
);

  localparam logic [SEQ_BEAT_W-1:0] LAST_BEAT = SEQ_BEAT_W'(N_COEFF - 1);

  seq_state_t                state_q, state_d;
  logic [SEQ_BEAT_W-1:0]     beat_q;
  logic [5:0]                op_q;
  logic                      out_valid_q;
  logic [COEFF_W-1:0]        out_data_q;
  logic [SEQ_BEAT_W-1:0]     out_idx_q;

  logic load_beat;
  logic store_beat;
  logic last_beat;
  logic wd_expired;

  assign load_beat  = (state_q == SEQ_LOAD)  && in_valid_i;
  assign store_beat = (state_q == SEQ_STORE) && ip_rdata_valid_i;
  assign last_beat  = (beat_q == LAST_BEAT);

`ifdef NTT_INTT_SEQ_TIMEOUT_EN
  logic wd_watch;
  logic wd_enter;

  // LOAD is paced by the host, so only the IP-paced states are watched.
  assign wd_watch = (state_q == SEQ_COMP_WAIT) || (state_q == SEQ_STORE) ||
                    (state_q == SEQ_STORE_WAIT);
  // Clearing on the transition edge makes the count 0 in the first cycle of each watched state.
  assign wd_enter = (state_d != state_q) &&
                    ((state_d == SEQ_COMP_WAIT) || (state_d == SEQ_STORE) ||
                     (state_d == SEQ_STORE_WAIT));

  ntt_intt_ip_seq_wdog #(
    .LIMIT(TIMEOUT_CYC)
  ) u_wdog (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .clr_i     (wd_enter),
    .en_i      (wd_watch),
    .expired_o (wd_expired)
  );
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYC == 0);
  assign wd_expired     = 1'b0;
`endif

  // Next-state logic. Exit conditions take priority over watchdog expiry.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      SEQ_IDLE: begin
        if (req_valid_i) state_d = op_is_valid(req_op_i) ? SEQ_LOAD_CMD : SEQ_ERR;
      end
      SEQ_LOAD_CMD:  state_d = SEQ_LOAD;
      SEQ_LOAD: begin
        if (load_beat && last_beat) state_d = SEQ_START;
      end
      SEQ_START:     state_d = SEQ_COMP_WAIT;
      SEQ_COMP_WAIT: begin
        if (ip_intr_i)       state_d = SEQ_STORE_CMD;
        else if (wd_expired) state_d = SEQ_ERR;
      end
      SEQ_STORE_CMD: state_d = SEQ_STORE;
      SEQ_STORE: begin
        if (store_beat && last_beat) state_d = SEQ_STORE_WAIT;
        else if (wd_expired)         state_d = SEQ_ERR;
      end
      SEQ_STORE_WAIT: begin
        if (ip_intr_i)       state_d = SEQ_DONE;
        else if (wd_expired) state_d = SEQ_ERR;
      end
      SEQ_DONE:      state_d = SEQ_IDLE;
      SEQ_ERR:       state_d = SEQ_IDLE;
      default:       state_d = SEQ_IDLE;
    endcase
  end

  // Command pulses and status are pure state decodes, so each lasts exactly one state cycle
  // and the intervening states guarantee a gap between any two commands.
  always_comb begin
    req_ready_o  = 1'b0;
    in_ready_o   = 1'b0;
    ip_load_o    = 1'b0;
    ip_start_o   = 1'b0;
    ip_store_o   = 1'b0;
    ip_load_en_o = 1'b0;
    done_o       = 1'b0;
    err_o        = 1'b0;
    busy_o       = (state_q != SEQ_IDLE);
    unique case (state_q)
      SEQ_IDLE:      req_ready_o = 1'b1;
      SEQ_LOAD_CMD:  ip_load_o   = 1'b1;
      SEQ_LOAD: begin
        in_ready_o   = 1'b1;
        ip_load_en_o = in_valid_i;
      end
      SEQ_START:     ip_start_o  = 1'b1;
      SEQ_STORE_CMD: ip_store_o  = 1'b1;
      SEQ_DONE:      done_o      = 1'b1;
      SEQ_ERR: begin
        done_o = 1'b1;
        err_o  = 1'b1;
      end
      default: ;
    endcase
  end

  assign ip_wdata_o     = in_data_i;
  assign ip_operation_o = op_q;
  assign out_valid_o    = out_valid_q;
  assign out_data_o     = out_data_q;
  assign out_idx_o      = out_idx_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= SEQ_IDLE;
      beat_q      <= '0;
      op_q        <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_idx_q   <= '0;
    end else begin
      state_q <= state_d;

      if (state_q == SEQ_IDLE && req_valid_i) op_q <= req_op_i;

      // One counter serves both phases; it is cleared on the last beat so STORE starts at 0.
      if (load_beat || store_beat) beat_q <= last_beat ? '0 : beat_q + 1'b1;

      out_valid_q <= store_beat;
      if (store_beat) begin
        out_data_q <= ip_rdata_i;
        out_idx_q  <= beat_q;
      end
    end
  end

endmodule

// File: tb/tb_ntt_intt_ip_seq.sv
// Purpose: directed self-checking bench for ntt_intt_ip_seq with a behavioural IP model.
// Latency: n/a.
// Backpressure: n/a.
module tb_ntt_intt_ip_seq;
  import ntt_intt_ip_pkg::*;

  localparam int N  = 256;
  localparam int W  = 12;
  localparam int TO = 2048;

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic          req_valid_i;
  logic          req_ready_o;
  logic [5:0]    req_op_i;
  logic          in_valid_i;
  logic          in_ready_o;
  logic [W-1:0]  in_data_i;
  logic          out_valid_o;
  logic [W-1:0]  out_data_o;
  logic [7:0]    out_idx_o;
  logic          done_o, err_o, busy_o;
  logic          ip_load_o, ip_start_o, ip_store_o, ip_load_en_o;
  logic [W-1:0]  ip_wdata_o;
  logic [5:0]    ip_operation_o;
  logic          ip_rdata_valid_i;
  logic [W-1:0]  ip_rdata_i;
  logic          ip_intr_i;

  ntt_intt_ip_seq #(.N_COEFF(N), .COEFF_W(W), .TIMEOUT_CYC(TO)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_op_i(req_op_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_data_i(in_data_i),
    .out_valid_o(out_valid_o), .out_data_o(out_data_o), .out_idx_o(out_idx_o),
    .done_o(done_o), .err_o(err_o), .busy_o(busy_o),
    .ip_load_o(ip_load_o), .ip_start_o(ip_start_o), .ip_store_o(ip_store_o),
    .ip_load_en_o(ip_load_en_o), .ip_wdata_o(ip_wdata_o), .ip_operation_o(ip_operation_o),
    .ip_rdata_valid_i(ip_rdata_valid_i), .ip_rdata_i(ip_rdata_i), .ip_intr_i(ip_intr_i)
  );

  always #5 clk_i = ~clk_i;

  int vectors     = 0;
  int miscompares = 0;

  // Event counters maintained by the monitor, read as before/after deltas by the main sequence.
  int n_load = 0, n_start = 0, n_store = 0, n_load_en = 0, n_out = 0;
  int n_done = 0, n_err = 0, out_bad = 0, wdata_bad = 0;
  int exp_idx = 0, exp_wdata = 0;

  function automatic logic [W-1:0] res_val(input int i);
    return W'((i * 37 + 5) % 4096);
  endfunction

  always @(posedge clk_i) begin
    if (ip_load_o) begin
      n_load++;
      exp_wdata = 0;
    end
    if (ip_start_o) n_start++;
    if (ip_store_o) begin
      n_store++;
      exp_idx = 0;
    end
    if (ip_load_en_o) begin
      n_load_en++;
      if (ip_wdata_o !== W'(exp_wdata)) wdata_bad++;
      exp_wdata++;
    end
    if (out_valid_o) begin
      n_out++;
      if (out_idx_o !== 8'(exp_idx) || out_data_o !== res_val(exp_idx)) out_bad++;
      exp_idx++;
    end
    if (done_o) n_done++;
    if (err_o)  n_err++;
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // mode 0: full job; mode 1: reset at store beat 100; mode 2: IP never interrupts.
  // A full job returns while the DUT sits in DONE.
  task automatic run_job(input logic [5:0] op, input bit gap, input bit spur,
                         input int mode, input string nm);
    int s_load, s_start, s_store, s_le, s_out, s_ob, s_wb, s_done;
    int i, c, k;
    s_load = n_load; s_start = n_start; s_store = n_store; s_le = n_load_en;
    s_out = n_out; s_ob = out_bad; s_wb = wdata_bad; s_done = n_done;

    chk({nm, "_idle_ready"}, 32'(req_ready_o), 32'd1);
    req_valid_i = 1'b1; req_op_i = op;
    tick();
    req_valid_i = 1'b0; req_op_i = '0;
    chk({nm, "_load_cmd"}, 32'(ip_load_o), 32'd1);
    chk({nm, "_op_latched"}, 32'(ip_operation_o), 32'(op));
    tick();
    chk({nm, "_load_in_ready"}, {30'd0, ip_load_o, in_ready_o}, 32'd1);

    i = 0; c = 0;
    while (i < N && c < 2000) begin
      in_valid_i = gap ? ((c % 2) == 0) : 1'b1;
      in_data_i  = W'(i);
      ip_intr_i  = spur && (c == 20);
      if (in_valid_i) i++;
      c++;
      tick();
      if (spur && c == 21) chk({nm, "_spur_still_load"}, 32'(in_ready_o), 32'd1);
    end
    in_valid_i = 1'b0; ip_intr_i = 1'b0;
    chk({nm, "_start_after_last"}, 32'(ip_start_o), 32'd1);
    chk({nm, "_load_en_count"}, 32'(n_load_en - s_le), 32'd256);
    chk({nm, "_wdata_ok"}, 32'(wdata_bad - s_wb), 32'd0);
    tick();
    chk({nm, "_comp_wait"}, {30'd0, ip_start_o, busy_o}, 32'd1);

    if (mode == 2) begin
`ifdef NTT_INTT_SEQ_TIMEOUT_EN
      k = 0;
      while (!done_o && k < 3000) begin
        tick();
        k++;
      end
      chk({nm, "_wdog_cycles"}, 32'(k), 32'd2048);
      chk({nm, "_wdog_err"}, 32'(err_o), 32'd1);
`else
      repeat (10000) tick();
      chk({nm, "_still_waiting"}, 32'(busy_o), 32'd1);
      chk({nm, "_no_done"}, 32'(n_done - s_done), 32'd0);
      rst_ni = 1'b0;
      tick();
      rst_ni = 1'b1;
`endif
      tick();
      return;
    end

    repeat (905) tick();
    chk({nm, "_no_early_store"}, 32'(ip_store_o), 32'd0);
    ip_intr_i = 1'b1;
    tick();
    ip_intr_i = 1'b0;
    chk({nm, "_store_cmd"}, 32'(ip_store_o), 32'd1);
    tick();

    for (int j = 0; j < N; j++) begin
      ip_rdata_valid_i = 1'b1;
      ip_rdata_i       = res_val(j);
      if (mode == 1 && j == 100) rst_ni = 1'b0;
      tick();
      if (mode == 1 && j == 100) begin
        chk({nm, "_rst_idle"}, {29'd0, req_ready_o, busy_o, out_valid_o}, 32'd4);
        rst_ni = 1'b1; ip_rdata_valid_i = 1'b0;
        s_load = n_load; s_start = n_start; s_store = n_store;
        repeat (5) tick();
        chk({nm, "_rst_no_pulses"},
            32'((n_load - s_load) + (n_start - s_start) + (n_store - s_store)), 32'd0);
        return;
      end
      if (j == 0) chk({nm, "_first_out"}, {23'd0, out_valid_o, out_idx_o}, 32'h100);
    end
    // Surplus beat while waiting for the store interrupt must not reach the output.
    ip_rdata_valid_i = 1'b1; ip_rdata_i = 12'hABC;
    tick();
    ip_rdata_valid_i = 1'b0;
    chk({nm, "_extra_dropped"}, 32'(out_valid_o), 32'd0);
    chk({nm, "_out_count"}, 32'(n_out - s_out), 32'd256);
    chk({nm, "_out_seq"}, 32'(out_bad - s_ob), 32'd0);
    repeat (3) tick();
    chk({nm, "_store_wait"}, {30'd0, done_o, busy_o}, 32'd1);
    ip_intr_i = 1'b1;
    tick();
    ip_intr_i = 1'b0;
    chk({nm, "_done_ok"}, {30'd0, done_o, err_o}, 32'd2);
    chk({nm, "_pulses"},
        {8'd0, 8'(n_load - s_load), 8'(n_start - s_start), 8'(n_store - s_store)},
        32'h010101);
  endtask

  initial begin
    int s_load;
    rst_ni = 1'b0; req_valid_i = 1'b0; req_op_i = '0; in_valid_i = 1'b0; in_data_i = '0;
    ip_rdata_valid_i = 1'b0; ip_rdata_i = '0; ip_intr_i = 1'b0;
    repeat (2) tick();
    chk("reset_ready_busy", {30'd0, req_ready_o, busy_o}, 32'd2);
    chk("reset_pulses", {25'd0, done_o, err_o, ip_load_o, ip_start_o, ip_store_o,
                         ip_load_en_o, out_valid_o}, 32'd0);
    chk("reset_op_idx", {18'd0, ip_operation_o, out_idx_o}, 32'd0);
    chk("reset_in_ready", 32'(in_ready_o), 32'd0);
    rst_ni = 1'b1;
    tick();

    run_job(OP_NTT, 1'b0, 1'b0, 0, "ntt");

    // Request raised during DONE waits one cycle, then a bad opcode goes straight to ERR.
    req_valid_i = 1'b1; req_op_i = 6'h3F;
    s_load = n_load;
    chk("done_blocks_req", 32'(req_ready_o), 32'd0);
    tick();
    chk("idle_after_done", 32'(req_ready_o), 32'd1);
    tick();
    req_valid_i = 1'b0; req_op_i = '0;
    chk("badop_err", {30'd0, done_o, err_o}, 32'd3);
    chk("badop_op", 32'(ip_operation_o), 32'h3F);
    tick();
    chk("badop_no_cmd", 32'(n_load - s_load), 32'd0);
    chk("badop_idle", 32'(req_ready_o), 32'd1);

    run_job(OP_INTT, 1'b1, 1'b0, 0, "gap");
    tick();
    run_job(OP_NTT, 1'b0, 1'b1, 0, "spur");
    tick();
    run_job(OP_NTT, 1'b0, 1'b0, 1, "rst");
    run_job(OP_INTT, 1'b0, 1'b0, 2, "wdog");
    chk("final_idle", 32'(req_ready_o), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
